// File: rtl/uart_pkg.sv
`default_nettype none
//============================================================================
// uart_pkg : shared types and helpers for the uart_tx_fifo transmitter
// Rev 1.0
//============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      NEXT  = 3'd5
   } state_t;

   localparam logic [63:0] c_ID_WORD_DEFAULT = 64'h00000000534c4131;

   // Clocks per bit, truncated toward zero.
   function automatic int calc_div(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
//============================================================================
// uart_tx_fifo_if : word-write bus between the readout core and the transmitter
// Rev 1.0
//============================================================================
interface uart_tx_fifo_if #(
   parameter int BYTES = 4,
   parameter int DEPTH = 16
) ();

   logic                     write;
   logic [8*BYTES-1:0]       wrdata;
   logic [BYTES-1:0]         disabled_groups;
   logic                     full;
   logic                     overflow;
   logic [$clog2(DEPTH):0]   level;

   modport master (
      output write,
      output wrdata,
      output disabled_groups,
      input  full,
      input  overflow,
      input  level
   );

   modport slave (
      input  write,
      input  wrdata,
      input  disabled_groups,
      output full,
      output overflow,
      output level
   );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_sync.sv
`default_nettype none
//============================================================================
// uart_fifo_sync : single-clock first-word-fall-through FIFO with occupancy
// Rev 1.0
//============================================================================
module uart_fifo_sync #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 16
) (
   input  wire logic                   clock,
   input  wire logic                   reset,
   input  wire logic                   push,
   input  wire logic [WIDTH-1:0]       din,
   input  wire logic                   pop,
   output logic      [WIDTH-1:0]       dout,
   output logic      [$clog2(DEPTH):0] level,
   output logic                        full,
   output logic                        empty
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_LVL_ONE = (c_PTR_W+1)'(1);
   localparam logic [c_PTR_W:0]   c_LVL_MAX = (c_PTR_W+1)'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_level;
   logic               w_push;
   logic               w_pop;

   // full/empty come from the pre-edge level, so a push while full is dropped
   // even when a pop happens in the same cycle.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LVL_ONE;
            2'b01:   r_level <= r_level - c_LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign level = r_level;
   assign full  = (r_level == c_LVL_MAX);
   assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
//============================================================================
// uart_tx_fifo : buffered multi-byte 8N1 transmitter with byte masking,
//                device-ID reply and xon/xoff flow control
// Rev 1.0
//============================================================================
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int          FREQ     = 100000000,
   parameter int          BAUDRATE = 115200,
   parameter int          BYTES    = 4,
   parameter int          DEPTH    = 16,
   parameter logic [63:0] ID_WORD  = c_ID_WORD_DEFAULT
) (
   input  wire logic     clock,
   input  wire logic     reset,
   uart_tx_fifo_if.slave bus,
   input  wire logic     id,
   input  wire logic     xon,
   input  wire logic     xoff,
   output logic          busy,
   output logic          uart_tx
);

   localparam int c_DIV   = calc_div(FREQ, BAUDRATE);
   localparam int c_CNT_W = $clog2(c_DIV + 1);
   localparam int c_LVL_W = $clog2(DEPTH) + 1;
   localparam int c_WIDTH = 9 * BYTES;

   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(c_DIV - 1);
   // The last clock of the stop bit is spent in NEXT, so STOP itself is one short.
   localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(c_DIV - 2);
   localparam logic [8*BYTES-1:0] c_ID        = ID_WORD[8*BYTES-1:0];

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [2:0]           r_bit;
   logic [7:0]           r_byte;
   logic [8*BYTES-1:0]   r_word;
   logic [BYTES-1:0]     r_pending;
   logic                 r_uart_tx;
   logic                 r_paused;
   logic                 r_id_pending;
   logic                 r_overflow;

   logic [c_WIDTH-1:0]   w_head;
   logic [c_LVL_W-1:0]   w_level;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_has_next;
   logic [BYTES-1:0]     w_sel_oh;
   logic [7:0]           w_next_byte;

   uart_fifo_sync #(
      .WIDTH (c_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (bus.write),
      .din   ({bus.disabled_groups, bus.wrdata}),
      .pop   (w_pop),
      .dout  (w_head),
      .level (w_level),
      .full  (w_full),
      .empty (w_empty)
   );

   // A pending ID takes the word slot ahead of the FIFO head.
   assign w_pop = (r_state == IDLE) && !r_id_pending && !w_empty;

   // Lowest still-pending byte of the current word.
   always_comb begin
      w_sel_oh    = '0;
      w_next_byte = '0;
      for (int i = BYTES - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_sel_oh    = '0;
            w_sel_oh[i] = 1'b1;
            w_next_byte = r_word[8*i +: 8];
         end
      end
   end

   assign w_has_next = |r_pending;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_paused     <= 1'b0;
         r_id_pending <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (xon) begin
            r_paused <= 1'b0;
         end else if (xoff) begin
            r_paused <= 1'b1;
         end
         if (id) begin
            r_id_pending <= 1'b1;
         end else if (r_state == IDLE) begin
            r_id_pending <= 1'b0;
         end
         if (bus.write && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_byte    <= '0;
         r_word    <= '0;
         r_pending <= '0;
         r_uart_tx <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_id_pending) begin
                  r_word    <= c_ID;
                  r_pending <= '1;
                  r_state   <= LOAD;
               end else if (!w_empty) begin
                  r_word    <= w_head[8*BYTES-1:0];
                  r_pending <= ~w_head[c_WIDTH-1 -: BYTES];
                  r_state   <= LOAD;
               end
            end
            // The byte is marked sent as it starts; NEXT then makes the same
            // decision as LOAD so frames within a word follow with no gap.
            LOAD, NEXT: begin
               if (!w_has_next) begin
                  r_state <= IDLE;
               end else if (!r_paused) begin
                  r_state   <= START;
                  r_cnt     <= '0;
                  r_uart_tx <= 1'b0;
                  r_byte    <= w_next_byte;
                  r_pending <= r_pending & ~w_sel_oh;
               end else begin
                  r_state <= LOAD;
               end
            end
            START: begin
               if (r_cnt == c_BIT_LAST) begin
                  r_state   <= DATA;
                  r_cnt     <= '0;
                  r_bit     <= '0;
                  r_uart_tx <= r_byte[0];
                  r_byte    <= {1'b0, r_byte[7:1]};
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            DATA: begin
               if (r_cnt == c_BIT_LAST) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_state   <= STOP;
                     r_uart_tx <= 1'b1;
                  end else begin
                     r_bit     <= r_bit + 3'd1;
                     r_uart_tx <= r_byte[0];
                     r_byte    <= {1'b0, r_byte[7:1]};
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            STOP: begin
               if (r_cnt == c_STOP_LAST) begin
                  r_state <= NEXT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_uart_tx <= 1'b1;
            end
         endcase
      end
   end

   assign bus.full     = w_full;
   assign bus.level    = w_level;
   assign bus.overflow = r_overflow;
   assign uart_tx      = r_uart_tx;
   assign busy         = !w_empty || r_id_pending || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
//============================================================================
// tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo (DIV=10)
// Rev 1.0
//============================================================================
module tb_uart_tx_fifo;

   localparam int DIV = 10;

   logic clock   = 1'b0;
   logic reset   = 1'b1;
   logic id      = 1'b0;
   logic xon     = 1'b0;
   logic xoff    = 1'b0;
   logic busy;
   logic uart_tx;

   uart_tx_fifo_if #(.BYTES(4), .DEPTH(4)) bus ();

   uart_tx_fifo #(
      .FREQ     (1000000),
      .BAUDRATE (100000),
      .BYTES    (4),
      .DEPTH    (4)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .id      (id),
      .xon     (xon),
      .xoff    (xoff),
      .busy    (busy),
      .uart_tx (uart_tx)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         n_asserts = 0;
   int         n_fail    = 0;
   logic [7:0] rx_q[$];
   bit         rx_ok[$];
   int         rx_t[$];
   logic [7:0] exp_q[$];
   int         t_push;
   int         tp;
   int         t_on;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Line receiver: samples each bit at its centre, away from clock edges.
   int         m_t0;
   logic [7:0] m_byte;
   logic       m_ok;
   initial begin
      forever begin
         @(negedge clock);
         if (uart_tx === 1'b0 && !reset) begin
            m_t0 = cyc;
            repeat (DIV/2) @(negedge clock);
            m_ok = (uart_tx === 1'b0);
            for (int b = 0; b < 8; b++) begin
               repeat (DIV) @(negedge clock);
               m_byte[b] = uart_tx;
            end
            repeat (DIV) @(negedge clock);
            m_ok = m_ok && (uart_tx === 1'b1);
            rx_q.push_back(m_byte);
            rx_ok.push_back(m_ok);
            rx_t.push_back(m_t0);
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic [3:0] m);
      bus.write           = 1'b1;
      bus.wrdata          = d;
      bus.disabled_groups = m;
      @(negedge clock);
      bus.write = 1'b0;
      t_push    = cyc;
   endtask

   function automatic int t_at(input int i);
      return (i < rx_t.size()) ? rx_t[i] : -100000;
   endfunction

   task automatic wait_frames(input string tag, input int n, input int budget);
      int i = 0;
      while (rx_q.size() < n && i < budget) begin
         @(negedge clock);
         i++;
      end
      check_eq({tag, "_frames_arrived"}, 64'(rx_q.size() >= n), 64'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int i = 0;
      while (busy !== 1'b0 && i < budget) begin
         @(negedge clock);
         i++;
      end
      check_eq({tag, "_busy_low"}, 64'(busy), 64'd0);
   endtask

   task automatic check_rx(input string tag);
      check_eq({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check_eq($sformatf("%s_frame%0d", tag, i), {55'd0, rx_ok[i], rx_q[i]},
                  {55'd0, 1'b1, exp_q[i]});
      end
      rx_q.delete();
      rx_ok.delete();
      rx_t.delete();
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.write           = 1'b0;
      bus.wrdata          = '0;
      bus.disabled_groups = '0;
      repeat (3) @(negedge clock);
      check_eq("rst_uart_tx",  64'(uart_tx),      64'd1);
      check_eq("rst_full",     64'(bus.full),     64'd0);
      check_eq("rst_overflow", 64'(bus.overflow), 64'd0);
      check_eq("rst_level",    64'(bus.level),    64'd0);
      check_eq("rst_busy",     64'(busy),         64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // 1: plain word, four contiguous frames
      push(32'h44332211, 4'b0000);
      tp = t_push;
      wait_frames("t1", 4, 600);
      check_eq("t1_latency", 64'(t_at(0) - tp), 64'd2);
      check_eq("t1_gap01", 64'(t_at(1) - t_at(0)), 64'd100);
      check_eq("t1_gap12", 64'(t_at(2) - t_at(1)), 64'd100);
      check_eq("t1_gap23", 64'(t_at(3) - t_at(2)), 64'd100);
      wait_idle("t1", 50);
      repeat (20) @(negedge clock);
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      check_rx("t1");

      // 2: masked bytes, then a fully masked word
      push(32'hAABBCCDD, 4'b0101);
      push(32'h12345678, 4'b1111);
      wait_frames("t2", 2, 400);
      check_eq("t2_gap", 64'(t_at(1) - t_at(0)), 64'd100);
      wait_idle("t2", 50);
      check_eq("t2_level", 64'(bus.level), 64'd0);
      repeat (150) @(negedge clock);
      exp_q = '{8'hCC, 8'hAA};
      check_rx("t2");

      // 3: xoff during byte 1, xon later
      push(32'h44332211, 4'b0000);
      repeat (132) @(negedge clock);
      xoff = 1'b1;
      @(negedge clock);
      xoff = 1'b0;
      repeat (500) @(negedge clock);
      check_eq("t3_paused_count", 64'(rx_q.size()), 64'd2);
      check_eq("t3_line_high",    64'(uart_tx),     64'd1);
      check_eq("t3_busy_paused",  64'(busy),        64'd1);
      xon = 1'b1;
      @(negedge clock);
      xon = 1'b0;
      t_on = cyc;
      wait_frames("t3", 4, 400);
      check_eq("t3_resume", 64'((t_at(2) - t_on) >= 1 && (t_at(2) - t_on) <= 2), 64'd1);
      check_eq("t3_gap23", 64'(t_at(3) - t_at(2)), 64'd100);
      wait_idle("t3", 50);
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      check_rx("t3");

      // 4: ID request during word A goes between A and B
      push(32'h0D0C0B0A, 4'b0000);
      push(32'h1D1C1B1A, 4'b0000);
      repeat (131) @(negedge clock);
      id = 1'b1;
      @(negedge clock);
      id = 1'b0;
      wait_frames("t4", 12, 1600);
      wait_idle("t4", 50);
      exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h31, 8'h41, 8'h4C, 8'h53,
                8'h1A, 8'h1B, 8'h1C, 8'h1D};
      check_rx("t4");

      // 5: overflow while paused mid-word
      push(32'h00002211, 4'b1100);
      repeat (30) @(negedge clock);
      xoff = 1'b1;
      @(negedge clock);
      xoff = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         push(32'hA0 + 32'(k), 4'b1110);
         if (k == 3) check_eq("t5_full_at3", 64'(bus.full), 64'd0);
         if (k == 4) begin
            check_eq("t5_full_at4",  64'(bus.full),     64'd1);
            check_eq("t5_level_at4", 64'(bus.level),    64'd4);
            check_eq("t5_ovf_at4",   64'(bus.overflow), 64'd0);
         end
      end
      check_eq("t5_ovf",   64'(bus.overflow), 64'd1);
      check_eq("t5_level", 64'(bus.level),    64'd4);
      check_eq("t5_full",  64'(bus.full),     64'd1);
      repeat (300) @(negedge clock);
      check_eq("t5_paused_count", 64'(rx_q.size()), 64'd1);
      xon = 1'b1;
      @(negedge clock);
      xon = 1'b0;
      wait_frames("t5", 6, 1000);
      wait_idle("t5", 50);
      check_eq("t5_level_end", 64'(bus.level), 64'd0);
      repeat (150) @(negedge clock);
      exp_q = '{8'h11, 8'h22, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      check_rx("t5");

      // 6: asynchronous reset during a zero data bit
      push(32'h44332211, 4'b0000);
      tp = t_push;
      push(32'h00000055, 4'b0000);
      push(32'h00000066, 4'b0000);
      repeat (23) @(negedge clock);
      check_eq("t6_pre_bit_low", 64'(uart_tx),      64'd0);
      check_eq("t6_pre_ovf",     64'(bus.overflow), 64'd1);
      check_eq("t6_pre_level",   64'(bus.level),    64'd2);
      reset = 1'b1;
      #1;
      check_eq("t6_rst_uart_tx",  64'(uart_tx),      64'd1);
      check_eq("t6_rst_busy",     64'(busy),         64'd0);
      check_eq("t6_rst_level",    64'(bus.level),    64'd0);
      check_eq("t6_rst_overflow", 64'(bus.overflow), 64'd0);
      check_eq("t6_rst_full",     64'(bus.full),     64'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (150) @(negedge clock);
      rx_q.delete();
      rx_ok.delete();
      rx_t.delete();
      push(32'h000000C3, 4'b1110);
      tp = t_push;
      wait_frames("t6", 1, 300);
      check_eq("t6_latency", 64'(t_at(0) - tp), 64'd2);
      wait_idle("t6", 50);
      exp_q = '{8'hC3};
      check_rx("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor transmitter for the analyzer UART link.
- Buffers outgoing sample words in a FIFO and serialises each word as up to BYTES 8N1 frames, low byte first.
- Applies a per-word disabled-group byte mask, inserts the device-ID reply, and obeys xon/xoff flow control.
- Sits between the capture/readout core (write/wrdata) and the uart_tx pin. Flags from the command decoder drive id, xon and xoff.

Parameters:
- FREQ, 100000000, system clock frequency in Hz.
- BAUDRATE, 115200, line rate. DIV = FREQ/BAUDRATE clocks per bit, truncated; DIV >= 2 is required.
- BYTES, 4, bytes per word, range 1..8.
- DEPTH, 16, FIFO depth in words; power of two, at least 2.
- ID_WORD, 64'h00000000534c4131, ID reply. The low BYTES bytes are sent, byte 0 first (default gives "1ALS").

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- write  in  1  push request for {wrdata, disabled_groups}.
- wrdata  in  8*BYTES  word to send.
- disabled_groups  in  BYTES  bit i=1 means byte i of this word is skipped; sampled with write.
- id  in  1  single-cycle request to send ID_WORD.
- xon  in  1  single-cycle resume.
- xoff  in  1  single-cycle pause.
- full  out  1  FIFO holds DEPTH words.
- overflow  out  1  sticky: a write was dropped.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FIFO non-empty, or ID pending, or a frame/word in progress.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Reset values: uart_tx=1, full=0, overflow=0, level=0, busy=0. Also cleared: paused=0, id_pending=0, state=IDLE.
- Reset takes effect immediately, including mid-frame. A truncated frame is acceptable and the FIFO is emptied.
- FIFO write:
  - write && !full pushes one entry.
  - write && full drops the entry and sets overflow. overflow is cleared only by reset.
  - full is evaluated from the pre-edge level, so a write while full is dropped even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave level unchanged.
- ID request: id sets id_pending. Further id pulses while pending merge into one request. id_pending clears when the ID word is loaded.
- Flow control: xoff sets paused; xon clears it. If both are asserted in the same cycle, xon wins.
- Pause granularity: pause is checked only before starting a byte. The frame in progress always completes; the remaining bytes of the current word wait.
- FSM states: IDLE, LOAD, START, DATA, STOP, NEXT.
  - IDLE: if id_pending, latch ID_WORD with mask 0. Else if FIFO non-empty, pop the head into the shift word and mask. Then go to LOAD.
  - LOAD: find the lowest unsent byte index i whose mask bit is 0.
    - If none exists, the word is done; go to IDLE (an all-masked word emits nothing).
    - Else, if !paused, go to START; otherwise hold in LOAD.
  - START: uart_tx=0 for DIV clocks.
  - DATA: 8 bits of byte i, LSB first, DIV clocks each.
  - STOP: uart_tx=1 for DIV clocks.
  - NEXT: mark byte i sent, return to LOAD.
- Bit timer: resets at each state entry and counts 0..DIV-1. A frame is exactly 10*DIV clocks, and back-to-back frames have no idle gap.
- Priority: a pending ID is sent only at a word boundary, before the next FIFO word. It is never interleaved inside a word.
- Latency: with a write at edge E0, FSM in IDLE, not paused and no ID pending, uart_tx goes low after edge E2.
- busy falls in the cycle the FSM returns to IDLE with the FIFO empty and no ID pending.

Decomposition:
- Package uart_pkg: FSM state enum, a DIV computation function, and the default ID constant.
- Sub-module uart_fifo_sync: single-clock FIFO of width 9*BYTES and depth DEPTH, with level/full/empty and asynchronous reset.
- The serialiser FSM stays in uart_tx_fifo.

Test Plan (FREQ=1000000, BAUDRATE=100000 so DIV=10, BYTES=4, DEPTH=4):
1. Write 0x44332211 with mask 0 -> frames 0x11, 0x22, 0x33, 0x44, 100 clocks each and 400 contiguous clocks in total. Start bit low after E2; busy=0 afterwards.
2. Write 0xAABBCCDD with mask 4'b0101, then 0x12345678 with mask 4'b1111 -> only 0xCC then 0xAA are sent. The second word emits nothing, and level reaches 0.
3. Send 0x44332211 and pulse xoff during the data bits of 0x22 -> 0x22 completes and the line stays high. Pulse xon 500 clocks later -> 0x33 starts within 2 clocks, then 0x44.
4. Write words A and B; pulse id during word A byte 1 -> all of A, then 0x31 0x41 0x4C 0x53, then B.
5. While paused, write 6 words -> full=1 after the 4th, overflow=1, level=4. After xon, exactly 4 words are sent.
6. Assert reset in the middle of a DATA bit of a byte whose current bit is 0 -> uart_tx=1 with no clock edge needed; busy=0, level=0, overflow=0. The next write transmits normally.
